// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file read side.
package regfile_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int REG_COUNT  = 32;
   localparam int ADDR_WIDTH = 5;
   localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/regfile_read_lane.sv
// One read lane: word select with zero rule and write bypass, plus held
// data/address registers that snoop writes while the result is stalled.
module regfile_read_lane
   import regfile_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] regs,
   input  reg_addr_t                       addr,
   input  logic                            load,
   input  logic                            hold,
   input  logic                            wr_en,
   input  reg_addr_t                       wr_addr,
   input  reg_word_t                       wr_data,
   output reg_word_t                       data
);
   reg_word_t words [REG_COUNT];
   reg_word_t data_reg;
   reg_word_t data_next;
   reg_addr_t addr_reg;
   reg_addr_t addr_next;
   logic      wr_live;

   genvar gi;
   generate
      for (gi = 0; gi < REG_COUNT; gi++) begin : g_words
         assign words[gi] = regs[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // A write to the zero register never reaches bypass or snoop.
   assign wr_live = wr_en && (wr_addr != ZERO_REG);

   always_comb begin
      data_next = data_reg;
      addr_next = addr_reg;
      if (load) begin
         addr_next = addr;
         if (addr == ZERO_REG)
            data_next = '0;
         else if (wr_live && (wr_addr == addr))
            data_next = wr_data;
         else
            data_next = words[addr];
      end else if (hold && wr_live && (wr_addr == addr_reg)) begin
         data_next = wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= '0;
         addr_reg <= '0;
      end else begin
         data_reg <= data_next;
         addr_reg <= addr_next;
      end
   end

   assign data = data_reg;
endmodule

// File: rtl/regfile_read_port.sv
// Dual read port: request/result handshake around two independent read lanes.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] regs,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [ADDR_WIDTH-1:0]           ReadRegister1,
   input  logic [ADDR_WIDTH-1:0]           ReadRegister2,
   input  logic                            wr_en,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   output logic                            rd_valid,
   input  logic                            rd_ready,
   output logic [DATA_WIDTH-1:0]           ReadData1,
   output logic [DATA_WIDTH-1:0]           ReadData2
);
   logic rd_valid_reg;
   logic rd_valid_next;
   logic accept;
   logic take;
   logic hold;

   // One-entry buffer: a new request may enter as the current result leaves.
   assign req_ready = reset_n && (!rd_valid_reg || rd_ready);
   assign accept    = req_valid && req_ready;
   assign take      = rd_valid_reg && rd_ready;
   assign hold      = rd_valid_reg && !rd_ready;

   always_comb begin
      rd_valid_next = rd_valid_reg;
      if (accept)
         rd_valid_next = 1'b1;
      else if (take)
         rd_valid_next = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rd_valid_reg <= 1'b0;
      else
         rd_valid_reg <= rd_valid_next;
   end

   assign rd_valid = rd_valid_reg;

   regfile_read_lane u_lane1 (
      .clk     (clk),
      .reset_n (reset_n),
      .regs    (regs),
      .addr    (ReadRegister1),
      .load    (accept),
      .hold    (hold),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (ReadData1)
   );

   regfile_read_lane u_lane2 (
      .clk     (clk),
      .reset_n (reset_n),
      .regs    (regs),
      .addr    (ReadRegister2),
      .load    (accept),
      .hold    (hold),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (ReadData2)
   );
endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: reset, basic read, zero rule, bypass,
// snoop under backpressure, back-to-back streaming and reset during a hold.
module tb_regfile_read_port;
   import regfile_pkg::*;

   logic                            clk;
   logic                            reset_n;
   logic [REG_COUNT*DATA_WIDTH-1:0] regs;
   logic                            req_valid;
   logic                            req_ready;
   logic [ADDR_WIDTH-1:0]           ReadRegister1;
   logic [ADDR_WIDTH-1:0]           ReadRegister2;
   logic                            wr_en;
   logic [ADDR_WIDTH-1:0]           wr_addr;
   logic [DATA_WIDTH-1:0]           wr_data;
   logic                            rd_valid;
   logic                            rd_ready;
   logic [DATA_WIDTH-1:0]           ReadData1;
   logic [DATA_WIDTH-1:0]           ReadData2;

   int checks;
   int failures;

   regfile_read_port dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .regs          (regs),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_reg(input int idx, input logic [DATA_WIDTH-1:0] val);
      regs[idx*DATA_WIDTH +: DATA_WIDTH] = val;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
      checks++; if (ReadData1 !== 64'h0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", ReadData1); end
      checks++; if (ReadData2 !== 64'h0) begin failures++; $display("FAIL reset_data2 got=%h exp=0", ReadData2); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
      step();
      reset_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", req_ready); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      set_reg(3, 64'hAAAA);
      set_reg(7, 64'h5555);
      rd_ready = 1'b1;
      req_valid = 1'b1; ReadRegister1 = 5'd3; ReadRegister2 = 5'd7;
      step();
      req_valid = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", rd_valid); end
      checks++; if (ReadData1 !== 64'hAAAA) begin failures++; $display("FAIL basic_data1 got=%h exp=%h", ReadData1, 64'hAAAA); end
      checks++; if (ReadData2 !== 64'h5555) begin failures++; $display("FAIL basic_data2 got=%h exp=%h", ReadData2, 64'h5555); end
      step();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_taken got=%0b exp=0", rd_valid); end
      $display("test_basic read (3,7) -> %h %h", ReadData1, ReadData2);
   endtask

   task automatic test_zero();
      set_reg(31, '1);
      rd_ready = 1'b1;
      req_valid = 1'b1; ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234;
      step();
      req_valid = 1'b0; wr_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%0b exp=1", rd_valid); end
      checks++; if (ReadData1 !== 64'h0) begin failures++; $display("FAIL zero_data1 got=%h exp=0", ReadData1); end
      checks++; if (ReadData2 !== 64'h0) begin failures++; $display("FAIL zero_data2 got=%h exp=0", ReadData2); end
      step();
      $display("test_zero read (31,31) with write to 31");
   endtask

   task automatic test_bypass();
      set_reg(5, 64'h10);
      set_reg(6, 64'h66);
      rd_ready = 1'b1;
      req_valid = 1'b1; ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h20;
      step();
      req_valid = 1'b0; wr_en = 1'b0;
      checks++; if (ReadData1 !== 64'h20) begin failures++; $display("FAIL bypass_data1 got=%h exp=%h", ReadData1, 64'h20); end
      checks++; if (ReadData2 !== 64'h66) begin failures++; $display("FAIL bypass_data2 got=%h exp=%h", ReadData2, 64'h66); end
      step();
      $display("test_bypass read (5,6) with write 5=0x20");
   endtask

   task automatic test_snoop();
      set_reg(4, 64'h44);
      set_reg(9, 64'h99);
      set_reg(1, 64'h11);
      set_reg(2, 64'h22);
      rd_ready = 1'b0;
      req_valid = 1'b1; ReadRegister1 = 5'd4; ReadRegister2 = 5'd9;
      step();
      // Keep offering a different request; it must not be accepted.
      ReadRegister1 = 5'd1; ReadRegister2 = 5'd2;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL snoop_valid got=%0b exp=1", rd_valid); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL snoop_ready1 got=%0b exp=0", req_ready); end
      checks++; if (ReadData1 !== 64'h44) begin failures++; $display("FAIL snoop_hold1_d1 got=%h exp=%h", ReadData1, 64'h44); end
      checks++; if (ReadData2 !== 64'h99) begin failures++; $display("FAIL snoop_hold1_d2 got=%h exp=%h", ReadData2, 64'h99); end
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hBEEF;
      step();
      wr_en = 1'b0;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL snoop_ready2 got=%0b exp=0", req_ready); end
      checks++; if (ReadData1 !== 64'h44) begin failures++; $display("FAIL snoop_hold2_d1 got=%h exp=%h", ReadData1, 64'h44); end
      checks++; if (ReadData2 !== 64'hBEEF) begin failures++; $display("FAIL snoop_update_d2 got=%h exp=%h", ReadData2, 64'hBEEF); end
      step();
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL snoop_ready3 got=%0b exp=0", req_ready); end
      checks++; if (ReadData2 !== 64'hBEEF) begin failures++; $display("FAIL snoop_hold3_d2 got=%h exp=%h", ReadData2, 64'hBEEF); end
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL snoop_valid3 got=%0b exp=1", rd_valid); end
      req_valid = 1'b0; rd_ready = 1'b1;
      step();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL snoop_drain got=%0b exp=0", rd_valid); end
      $display("test_snoop held (4,9), lane2 snooped to BEEF");
   endtask

   task automatic test_back_to_back();
      logic [DATA_WIDTH-1:0] exp1;
      logic [DATA_WIDTH-1:0] exp2;
      for (int i = 0; i < 8; i++) set_reg(i, 64'h100 + 64'(i));
      rd_ready = 1'b1;
      req_valid = 1'b1; ReadRegister1 = 5'd0; ReadRegister2 = 5'd1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%0b exp=1", k, req_ready); end
         step();
         exp1 = 64'h100 + 64'(2*k);
         exp2 = 64'h100 + 64'(2*k + 1);
         if (k < 3) begin
            ReadRegister1 = 5'(2*k + 2); ReadRegister2 = 5'(2*k + 3);
         end else begin
            req_valid = 1'b0;
         end
         checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid k=%0d got=%0b exp=1", k, rd_valid); end
         checks++; if (ReadData1 !== exp1) begin failures++; $display("FAIL b2b_data1 k=%0d got=%h exp=%h", k, ReadData1, exp1); end
         checks++; if (ReadData2 !== exp2) begin failures++; $display("FAIL b2b_data2 k=%0d got=%h exp=%h", k, ReadData2, exp2); end
         $display("test_back_to_back result %0d -> %h %h", k, ReadData1, ReadData2);
      end
      step();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", rd_valid); end
   endtask

   task automatic test_reset_mid_hold();
      set_reg(3, 64'hAAAA);
      set_reg(7, 64'h5555);
      rd_ready = 1'b0;
      req_valid = 1'b1; ReadRegister1 = 5'd3; ReadRegister2 = 5'd7;
      step();
      req_valid = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rmh_valid_before got=%0b exp=1", rd_valid); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rmh_valid got=%0b exp=0", rd_valid); end
      checks++; if (ReadData1 !== 64'h0) begin failures++; $display("FAIL rmh_data1 got=%h exp=0", ReadData1); end
      checks++; if (ReadData2 !== 64'h0) begin failures++; $display("FAIL rmh_data2 got=%h exp=0", ReadData2); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rmh_ready_low got=%0b exp=0", req_ready); end
      step();
      reset_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmh_ready_after got=%0b exp=1", req_ready); end
      step();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rmh_no_replay got=%0b exp=0", rd_valid); end
      $display("test_reset_mid_hold done");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      regs = '0;
      req_valid = 1'b0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_ready = 1'b0;
      reset_n = 1'b1;
      test_reset();
      test_basic();
      test_zero();
      test_bypass();
      test_snoop();
      test_back_to_back();
      test_reset_mid_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
